plic_irq_axil_sink: RTL
=======================

// Module: plic_irq_axil_sink
// PURPOSE
//  AXI4-Lite slave on the PLIC wrapper's master port (m02 side of the peripheral block).
//  Consumes PLIC interrupt-notification writes and holds a per-target IRQ level register.
//  Drives level interrupt lines irq_o[] into the BlackParrot core, with readback and an edge counter.
//  Single clock domain (aclk); asynchronous, active-high reset.
// PARAMETERS
//  axil_addr_width_p  32  AXI-Lite address width.
//  axil_data_width_p  32  AXI-Lite data width; only 32 is supported.
//  num_targets_p      2   Number of IRQ targets (1..16); target i register at offset 4*i.
// PORTS
//  aclk             in   1      Clock.
//  reset_i          in   1      Asynchronous, active-high reset.
//  s00_axi_aw*      in/out  addr/3/1/1  awaddr, awprot (ignored), awvalid, awready.
//  s00_axi_w*       in/out  32/4/1/1    wdata, wstrb, wvalid, wready.
//  s00_axi_b*       out/in  2/1/1       bresp, bvalid, bready.
//  s00_axi_ar*      in/out  addr/3/1/1  araddr, arprot (ignored), arvalid, arready.
//  s00_axi_r*       out/in  32/2/1/1    rdata, rresp, rvalid, rready.
//  irq_o            out  num_targets_p  Level interrupt per target; bit i = IRQ_i[0].
// BEHAVIOUR
//  Register map (decoded on addr[7:0]; upper bits ignored):
//   - 0x00+4*i IRQ_i (RW): bit0 = level; other bits read 0.
//   - 0x80 EVT_CNT (RW): 32b count of rising edges on any irq_o bit. Increments by 1 per
//     cycle with >=1 rising edge; wraps 0xFFFF_FFFF->0. Any write clears it to 0.
//   - Other offsets: SLVERR (2'b10); no state change; rdata=0.
//  Reset (async): all IRQ_i=0, EVT_CNT=0, irq_o=0, bvalid=0, rvalid=0, bresp=rresp=0, rdata=0.
//   awready/wready/arready are 0 while reset_i=1 and 1 in the first cycle after release.
//  Write path:
//   - AW and W are accepted independently, each into a one-entry hold register.
//   - awready = !aw_held & !bvalid; wready = !w_held & !bvalid.
//   - Commit occurs in the cycle both AW and W are available (held or handshaking now).
//   - Commit effects, visible next cycle: IRQ_i/EVT_CNT update, bvalid=1 with bresp, holds cleared.
//   - AW+W handshaked in cycle N -> bvalid and new irq_o in cycle N+1.
//   - bvalid holds until bready; no new AW/W is accepted while bvalid=1.
//   - IRQ_i bit0 updates only when wstrb[0]=1; otherwise OKAY with no change.
//  Read path:
//   - arready = !rvalid. AR handshake in cycle N -> rvalid and rdata in cycle N+1.
//   - rdata is sampled from register state at cycle N (pre-write if a commit coincides).
//   - rvalid, rdata and rresp are held stable until rready.
//  Edge counter:
//   - Rising edge = irq_o & ~irq_q, where irq_q is a registered copy of irq_o.
//   - If an EVT_CNT write commit and an edge coincide, the clear wins (result 0).
//  Read and write paths are fully independent; simultaneous AR and AW/W are both served.
//  awprot and arprot are ignored.
//  Reset mid-transaction: holds and pending responses are dropped; no response is owed after reset.
// STRUCTURE
//  - Package plic_irq_sink_pkg: register offset localparams (IRQ base 0x00, EVT_CNT 0x80),
//    resp codes (OKAY 2'b00, SLVERR 2'b10), and decoded-write struct {offset, data, strb}.
//  - Sub-module plic_irq_sink_wr_join: AW/W one-entry holds + join, emits a commit pulse
//    and the decoded-write struct.
//  - The top holds registers, read port and edge counter.
// TESTING
//  1. Reset release: all outputs 0, readies 1 next cycle; read 0x00 -> rdata 0, OKAY.
//  2. AW(0x04)+W(1, strb F) same cycle N:
//     -> irq_o=2'b10 and bvalid at N+1; EVT_CNT reads 1.
//  3. W(1) at N, AW(0x00) at N+3, bready=0 for 5 cycles:
//     -> single commit at N+3; bvalid held; awready=0 until bready.
//  4. Write 0x40 -> bresp 2'b10, irq_o unchanged; read 0x44 -> rresp 2'b10, rdata 0.
//  5. Preload EVT_CNT to 0xFFFF_FFFF via forced edges/backdoor, then one edge -> reads 0.
//     Write to 0x80 coinciding with an edge -> reads 0.
//  6. Assert reset_i mid-write with bvalid pending and rready=0:
//     -> bvalid, rvalid, irq_o drop to 0 immediately.

Source files
------------

// File: rtl/plic_irq_sink_pkg.sv
// Shared definitions for the PLIC IRQ sink: register offsets, response codes, decoded write.
// Latency: none (types, constants and a pure decode helper only).
// Backpressure: not applicable.
package plic_irq_sink_pkg;

  localparam logic [7:0] IRQ_BASE_OFF = 8'h00;
  localparam logic [7:0] EVT_CNT_OFF  = 8'h80;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  // A fully joined AW+W write, offset already reduced to the decoded byte range.
  typedef struct packed {
    logic [7:0]  offset;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;

  // True when the offset is a word-aligned IRQ_i register of an existing target.
  function automatic logic is_irq_off(input logic [7:0] off, input int num_targets);
    logic [7:0] rel;
    rel = off - IRQ_BASE_OFF;
    return (rel[1:0] == 2'b00) && (int'(rel[7:2]) < num_targets);
  endfunction

endpackage

// File: rtl/plic_irq_sink_wr_join.sv
// Joins independent AW and W channels through one-entry holds into a single commit pulse.
// Latency: commit is combinational in the cycle the second half arrives (held or handshaking).
// Backpressure: each channel stalls while its hold is full or a write response is pending.
module plic_irq_sink_wr_join
  import plic_irq_sink_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_aw_off,
  input  logic        i_aw_vld,
  output logic        o_aw_rdy,
  input  logic [31:0] i_w_dat,
  input  logic [3:0]  i_w_strb,
  input  logic        i_w_vld,
  output logic        o_w_rdy,
  input  logic        i_b_busy,
  output logic        o_commit,
  output wr_req_t     o_req
);

  logic        r_aw_held;
  logic [7:0]  r_aw_off;
  logic        r_w_held;
  logic [31:0] r_w_dat;
  logic [3:0]  r_w_strb;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_avail;
  logic w_w_avail;

  // Readies drop during reset so nothing is accepted before the block is live.
  assign o_aw_rdy   = !rst && !r_aw_held && !i_b_busy;
  assign o_w_rdy    = !rst && !r_w_held && !i_b_busy;
  assign w_aw_hs    = i_aw_vld && o_aw_rdy;
  assign w_w_hs     = i_w_vld && o_w_rdy;
  assign w_aw_avail = r_aw_held || w_aw_hs;
  assign w_w_avail  = r_w_held || w_w_hs;
  assign o_commit   = w_aw_avail && w_w_avail;

  // A held half always wins over the live bus, since its ready is low anyway.
  assign o_req.offset = r_aw_held ? r_aw_off : i_aw_off;
  assign o_req.data   = r_w_held  ? r_w_dat  : i_w_dat;
  assign o_req.strb   = r_w_held  ? r_w_strb : i_w_strb;

  // Capture a lone half; release both holds when the pair commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_held <= 1'b0;
      r_aw_off  <= '0;
      r_w_held  <= 1'b0;
      r_w_dat   <= '0;
      r_w_strb  <= '0;
    end else begin
      if (o_commit) begin
        r_aw_held <= 1'b0;
      end else if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_off  <= i_aw_off;
      end
      if (o_commit) begin
        r_w_held <= 1'b0;
      end else if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_dat  <= i_w_dat;
        r_w_strb <= i_w_strb;
      end
    end
  end

endmodule

// File: rtl/plic_irq_axil_sink.sv
// AXI4-Lite sink for PLIC notifications: per-target IRQ level registers plus a rising-edge counter.
// Latency: write commit -> bvalid/irq_o next cycle; AR handshake -> rvalid/rdata next cycle.
// Backpressure: AW/W stall while a hold is full or bvalid is pending; AR stalls while rvalid is pending.
module plic_irq_axil_sink
  import plic_irq_sink_pkg::*;
#(
  parameter int axil_addr_width_p = 32,
  parameter int axil_data_width_p = 32,
  parameter int num_targets_p     = 2
)(
  input  logic                           aclk,
  input  logic                           reset_i,
  input  logic [axil_addr_width_p-1:0]   s00_axi_awaddr,
  input  logic [2:0]                     s00_axi_awprot,
  input  logic                           s00_axi_awvalid,
  output logic                           s00_axi_awready,
  input  logic [axil_data_width_p-1:0]   s00_axi_wdata,
  input  logic [axil_data_width_p/8-1:0] s00_axi_wstrb,
  input  logic                           s00_axi_wvalid,
  output logic                           s00_axi_wready,
  output logic [1:0]                     s00_axi_bresp,
  output logic                           s00_axi_bvalid,
  input  logic                           s00_axi_bready,
  input  logic [axil_addr_width_p-1:0]   s00_axi_araddr,
  input  logic [2:0]                     s00_axi_arprot,
  input  logic                           s00_axi_arvalid,
  output logic                           s00_axi_arready,
  output logic [axil_data_width_p-1:0]   s00_axi_rdata,
  output logic [1:0]                     s00_axi_rresp,
  output logic                           s00_axi_rvalid,
  input  logic                           s00_axi_rready,
  output logic [num_targets_p-1:0]       irq_o
);

  logic [num_targets_p-1:0]     r_irq;
  logic [num_targets_p-1:0]     r_irq_q;
  logic [31:0]                  r_evt_cnt;
  logic                         r_bvalid;
  logic [1:0]                   r_bresp;
  logic                         r_rvalid;
  logic [axil_data_width_p-1:0] r_rdata;
  logic [1:0]                   r_rresp;

  logic                         w_commit;
  wr_req_t                      w_req;
  logic                         w_wr_irq;
  logic                         w_wr_evt;
  logic                         w_edge;
  logic                         w_ar_hs;
  logic [7:0]                   w_ar_off;
  logic [axil_data_width_p-1:0] w_rd_dat;
  logic [1:0]                   w_rd_resp;
  logic                         w_unused;

  plic_irq_sink_wr_join u_wr_join (
    .clk      (aclk),
    .rst      (reset_i),
    .i_aw_off (s00_axi_awaddr[7:0]),
    .i_aw_vld (s00_axi_awvalid),
    .o_aw_rdy (s00_axi_awready),
    .i_w_dat  (s00_axi_wdata),
    .i_w_strb (s00_axi_wstrb),
    .i_w_vld  (s00_axi_wvalid),
    .o_w_rdy  (s00_axi_wready),
    .i_b_busy (r_bvalid),
    .o_commit (w_commit),
    .o_req    (w_req)
  );

  assign w_wr_irq = is_irq_off(w_req.offset, num_targets_p);
  assign w_wr_evt = (w_req.offset == EVT_CNT_OFF);
  assign w_edge   = |(r_irq & ~r_irq_q);

  assign w_ar_off        = s00_axi_araddr[7:0];
  assign s00_axi_arready = !reset_i && !r_rvalid;
  assign w_ar_hs         = s00_axi_arvalid && s00_axi_arready;

  assign irq_o          = r_irq;
  assign s00_axi_bvalid = r_bvalid;
  assign s00_axi_bresp  = r_bresp;
  assign s00_axi_rvalid = r_rvalid;
  assign s00_axi_rdata  = r_rdata;
  assign s00_axi_rresp  = r_rresp;

  // Protection bits, upper address bits and unused data/strobe lanes carry no meaning here.
  assign w_unused = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                      s00_axi_awaddr[axil_addr_width_p-1:8], s00_axi_araddr[axil_addr_width_p-1:8],
                      w_req.data[31:1], w_req.strb[3:1]};

  // IRQ level registers: only byte lane 0 carries the level bit.
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      r_irq <= '0;
    end else if (w_commit && w_wr_irq && w_req.strb[0]) begin
      for (int i = 0; i < num_targets_p; i++) begin
        if (int'(w_req.offset[7:2]) == i) r_irq[i] <= w_req.data[0];
      end
    end
  end

  // Delayed copy of irq_o for edge detection, and the edge counter where a write clear beats an edge.
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      r_irq_q   <= '0;
      r_evt_cnt <= '0;
    end else begin
      r_irq_q <= r_irq;
      if (w_commit && w_wr_evt) r_evt_cnt <= '0;
      else if (w_edge)          r_evt_cnt <= r_evt_cnt + 32'd1;
    end
  end

  // Write response: raised by a commit, held until bready.
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= (w_wr_irq || w_wr_evt) ? RESP_OKAY : RESP_SLVERR;
    end else if (s00_axi_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read mux over current (pre-commit) register state.
  always_comb begin
    w_rd_dat  = '0;
    w_rd_resp = RESP_SLVERR;
    if (w_ar_off == EVT_CNT_OFF) begin
      w_rd_dat  = r_evt_cnt;
      w_rd_resp = RESP_OKAY;
    end else if (is_irq_off(w_ar_off, num_targets_p)) begin
      w_rd_resp = RESP_OKAY;
      for (int i = 0; i < num_targets_p; i++) begin
        if (int'(w_ar_off[7:2]) == i) w_rd_dat[0] = r_irq[i];
      end
    end
  end

  // Read response: captured on AR handshake, held stable until rready.
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_dat;
      r_rresp  <= w_rd_resp;
    end else if (s00_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule
